// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin byte bus arbiter routing masters to RAM or IO
//
// Ports:
//   clk_in, rst_n_in        clock (rising edge), asynchronous active-low reset
//   pause_in                blocks selection and grants while high
//   m_req_in/m_addr_in/m_wr_in/m_dout_in   per-master request, packed address, write flag, write data
//   m_gnt_out/m_rvalid_out/m_din_out       one-hot grant, one-hot read valid, shared read data
//   ram_en_out/ram_wr_out/ram_a_out/ram_d_out/ram_q_in   RAM port (1-cycle read latency)
//   io_en_out/io_wr_out/io_sel_out/io_d_out/io_q_in/io_full_in   IO port
//   owner_out, busy_out     current owner index, high while a master owns the bus
module mem_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int MAX_BURST      = 16,
    localparam int OW            = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              pause_in,
    input  logic [NUM_MASTERS-1:0]            m_req_in,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_in,
    input  logic [NUM_MASTERS-1:0]            m_wr_in,
    input  logic [NUM_MASTERS*8-1:0]          m_dout_in,
    output logic [NUM_MASTERS-1:0]            m_gnt_out,
    output logic [NUM_MASTERS-1:0]            m_rvalid_out,
    output logic [7:0]                        m_din_out,
    output logic                              ram_en_out,
    output logic                              ram_wr_out,
    output logic [RAM_ADDR_WIDTH-1:0]         ram_a_out,
    output logic [7:0]                        ram_d_out,
    input  logic [7:0]                        ram_q_in,
    output logic                              io_en_out,
    output logic                              io_wr_out,
    output logic [2:0]                        io_sel_out,
    output logic [7:0]                        io_d_out,
    input  logic [7:0]                        io_q_in,
    input  logic                              io_full_in,
    output logic [OW-1:0]                     owner_out,
    output logic                              busy_out
);

    typedef enum logic {ST_IDLE, ST_OWNED} state_t;

    localparam logic [4:0] LP_MAX = 5'(MAX_BURST);

    state_t                  r_state, w_state_next;
    logic [OW-1:0]           r_owner, r_rr_ptr, r_rd_owner;
    logic [4:0]              r_count;
    logic                    r_rd_pend, r_rd_io;

    logic [ADDR_WIDTH-1:0]   w_addr;
    logic                    w_wr;
    logic [7:0]              w_dout;
    logic [NUM_MASTERS-1:0]  w_own_oh;
    logic                    w_req_own, w_others, w_is_io, w_stall, w_grant, w_exit;
    logic [4:0]              w_cnt_next;
    logic [OW-1:0]           w_sel_idx, w_rr_next;
    logic                    w_sel_found;
    logic                    w_unused;

    // Owner's request fields
    always_comb begin
        w_addr   = '0;
        w_wr     = 1'b0;
        w_dout   = '0;
        w_own_oh = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_owner == OW'(i)) begin
                w_addr      = m_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wr        = m_wr_in[i];
                w_dout      = m_dout_in[i*8 +: 8];
                w_own_oh[i] = 1'b1;
            end
        end
    end

    assign w_req_own = |(m_req_in & w_own_oh);
    assign w_others  = |(m_req_in & ~w_own_oh);
    assign w_is_io   = (w_addr[RAM_ADDR_WIDTH -: 2] == 2'b11);
    // Only a write into a full IO queue stalls; IO reads always proceed.
    assign w_stall   = pause_in | (w_is_io & w_wr & io_full_in);
    assign w_grant   = (r_state == ST_OWNED) & w_req_own & ~w_stall;
    assign w_cnt_next = (w_grant && r_count != 5'd31) ? r_count + 5'd1 : r_count;
    assign w_rr_next = (r_owner == OW'(NUM_MASTERS - 1)) ? '0 : r_owner + OW'(1);

    // Round-robin pick: first requester at or after r_rr_ptr
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!w_sel_found && m_req_in[i] &&
                    ((int'(r_rr_ptr) + k) % NUM_MASTERS) == i) begin
                    w_sel_found = 1'b1;
                    w_sel_idx   = i[OW-1:0];
                end
            end
        end
    end

    // Exit is judged on the post-grant count so the MAX_BURST-th grant
    // is the last one, leaving a single IDLE cycle between owners.
    always_comb begin
        w_state_next = r_state;
        w_exit       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_found && !pause_in) w_state_next = ST_OWNED;
            end
            ST_OWNED: begin
                if (!w_req_own || (w_cnt_next >= LP_MAX && w_others)) begin
                    w_state_next = ST_IDLE;
                    w_exit       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= ST_IDLE;
        else           r_state <= w_state_next;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_count    <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= '0;
            r_rd_io    <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_state_next == ST_OWNED) begin
                    r_owner <= w_sel_idx;
                    r_count <= '0;
                end
            end else begin
                r_count <= w_cnt_next;
                if (w_exit) r_rr_ptr <= w_rr_next;
            end
            r_rd_pend  <= w_grant & ~w_wr;
            r_rd_owner <= r_owner;
            r_rd_io    <= w_is_io;
        end
    end

    // Access strobes; address/data are zeroed when not strobed
    assign m_gnt_out  = w_grant ? w_own_oh : '0;
    assign ram_en_out = w_grant & ~w_is_io;
    assign ram_wr_out = ram_en_out & w_wr;
    assign ram_a_out  = ram_en_out ? w_addr[RAM_ADDR_WIDTH-1:0] : '0;
    assign ram_d_out  = ram_wr_out ? w_dout : '0;
    assign io_en_out  = w_grant & w_is_io;
    assign io_wr_out  = io_en_out & w_wr;
    assign io_sel_out = io_en_out ? w_addr[2:0] : '0;
    assign io_d_out   = io_wr_out ? w_dout : '0;

    // Read return uses the owner captured at grant time, independent of
    // whatever ownership or pause does in the return cycle.
    always_comb begin
        m_rvalid_out = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_rd_pend && r_rd_owner == OW'(i)) m_rvalid_out[i] = 1'b1;
        end
    end

    assign m_din_out = r_rd_pend ? (r_rd_io ? io_q_in : ram_q_in) : 8'd0;
    assign owner_out = r_owner;
    assign busy_out  = (r_state == ST_OWNED);

    assign w_unused = ^{1'b0, w_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+1]};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    localparam int NM  = 2;
    localparam int AW  = 32;
    localparam int RAW = 17;
    localparam int MB  = 4;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             pause_in;
    logic [NM-1:0]    m_req_in;
    logic [NM*AW-1:0] m_addr_in;
    logic [NM-1:0]    m_wr_in;
    logic [NM*8-1:0]  m_dout_in;
    logic [NM-1:0]    m_gnt_out;
    logic [NM-1:0]    m_rvalid_out;
    logic [7:0]       m_din_out;
    logic             ram_en_out, ram_wr_out;
    logic [RAW-1:0]   ram_a_out;
    logic [7:0]       ram_d_out, ram_q_in;
    logic             io_en_out, io_wr_out;
    logic [2:0]       io_sel_out;
    logic [7:0]       io_d_out, io_q_in;
    logic             io_full_in;
    logic [0:0]       owner_out;
    logic             busy_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;

    mem_bus_arbiter #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW), .MAX_BURST(MB)
    ) u_dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .pause_in(pause_in),
        .m_req_in(m_req_in), .m_addr_in(m_addr_in), .m_wr_in(m_wr_in),
        .m_dout_in(m_dout_in), .m_gnt_out(m_gnt_out), .m_rvalid_out(m_rvalid_out),
        .m_din_out(m_din_out), .ram_en_out(ram_en_out), .ram_wr_out(ram_wr_out),
        .ram_a_out(ram_a_out), .ram_d_out(ram_d_out), .ram_q_in(ram_q_in),
        .io_en_out(io_en_out), .io_wr_out(io_wr_out), .io_sel_out(io_sel_out),
        .io_d_out(io_d_out), .io_q_in(io_q_in), .io_full_in(io_full_in),
        .owner_out(owner_out), .busy_out(busy_out)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk_in);
        #1;
    endtask

    task automatic smp;
        @(negedge clk_in);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_gnt"}, 32'(m_gnt_out), 32'h0);
        check_val({tag, "_rvalid"}, 32'(m_rvalid_out), 32'h0);
        check_val({tag, "_din"}, 32'(m_din_out), 32'h0);
        check_val({tag, "_ram_en"}, 32'(ram_en_out), 32'h0);
        check_val({tag, "_io_en"}, 32'(io_en_out), 32'h0);
        check_val({tag, "_owner"}, 32'(owner_out), 32'h0);
        check_val({tag, "_busy"}, 32'(busy_out), 32'h0);
    endtask

    int exp_g [16] = '{0, 1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 1, 1, 1, 1, 0};
    int prev_g;

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst_n_in   = 1'b0;
        pause_in   = 1'b0;
        m_req_in   = '0;
        m_addr_in  = '0;
        m_wr_in    = '0;
        m_dout_in  = '0;
        ram_q_in   = 8'h00;
        io_q_in    = 8'h00;
        io_full_in = 1'b0;

        // Reset state
        smp;
        check_quiet("rst");

        // Master 0 RAM read of 0x00010, RAM returns 0xA5
        cyc;
        rst_n_in  = 1'b1;
        m_req_in  = 2'b01;
        m_addr_in[0 +: AW] = 32'h0001_0;
        ram_q_in  = 8'hA5;
        smp;
        check_val("rd_sel_gnt", 32'(m_gnt_out), 32'h0);
        check_val("rd_sel_busy", 32'(busy_out), 32'h0);
        cyc;
        smp;
        check_val("rd_gnt", 32'(m_gnt_out), 32'h1);
        check_val("rd_ram_en", 32'(ram_en_out), 32'h1);
        check_val("rd_io_en", 32'(io_en_out), 32'h0);
        check_val("rd_ram_a", 32'(ram_a_out), 32'h10);
        check_val("rd_ram_wr", 32'(ram_wr_out), 32'h0);
        check_val("rd_busy", 32'(busy_out), 32'h1);
        cyc;
        m_req_in = 2'b00;
        smp;
        check_val("rd_rvalid", 32'(m_rvalid_out), 32'h1);
        check_val("rd_din", 32'(m_din_out), 32'hA5);
        check_val("rd_gnt_off", 32'(m_gnt_out), 32'h0);

        // Master 1 IO write 0x41 to 0x30000 against a full IO queue
        cyc;
        m_req_in   = 2'b10;
        m_addr_in[AW +: AW] = 32'h0003_0000;
        m_wr_in    = 2'b10;
        m_dout_in[8 +: 8] = 8'h41;
        io_full_in = 1'b1;
        smp;
        check_val("io_sel_gnt", 32'(m_gnt_out), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc;
            smp;
            check_val("io_full_en", 32'(io_en_out), 32'h0);
            check_val("io_full_gnt", 32'(m_gnt_out), 32'h0);
            check_val("io_full_owner", 32'(owner_out), 32'h1);
        end
        cyc;
        io_full_in = 1'b0;
        smp;
        check_val("io_gnt", 32'(m_gnt_out), 32'h2);
        check_val("io_en", 32'(io_en_out), 32'h1);
        check_val("io_wr", 32'(io_wr_out), 32'h1);
        check_val("io_sel", 32'(io_sel_out), 32'h0);
        check_val("io_d", 32'(io_d_out), 32'h41);
        check_val("io_ram_en", 32'(ram_en_out), 32'h0);
        cyc;
        m_req_in = 2'b00;
        m_wr_in  = 2'b00;
        smp;
        check_val("io_done_en", 32'(io_en_out), 32'h0);
        check_val("io_done_rvalid", 32'(m_rvalid_out), 32'h0);

        // Both masters read continuously: runs of MB grants with one idle gap
        prev_g = 0;
        for (int i = 0; i < 16; i++) begin
            cyc;
            if (i == 0) begin
                m_req_in = 2'b11;
                m_addr_in[0 +: AW]  = 32'h10;
                m_addr_in[AW +: AW] = 32'h20;
            end
            smp;
            check_val($sformatf("burst_gnt%0d", i), 32'(m_gnt_out), 32'(exp_g[i]));
            check_val($sformatf("burst_rv%0d", i), 32'(m_rvalid_out), 32'(prev_g));
            prev_g = exp_g[i];
        end
        cyc;
        m_req_in = 2'b00;
        smp;
        check_val("burst_end_gnt", 32'(m_gnt_out), 32'h0);

        // Pause for 2 cycles mid-burst; the read just before still returns
        cyc;
        m_req_in = 2'b01;
        ram_q_in = 8'h5A;
        smp;
        cyc;
        smp;
        check_val("pz_pre_gnt", 32'(m_gnt_out), 32'h1);
        for (int i = 0; i < 2; i++) begin
            cyc;
            pause_in = 1'b1;
            smp;
            check_val("pz_gnt", 32'(m_gnt_out), 32'h0);
            check_val("pz_ram_en", 32'(ram_en_out), 32'h0);
            check_val("pz_owner", 32'(owner_out), 32'h0);
            check_val("pz_busy", 32'(busy_out), 32'h1);
            check_val("pz_rvalid", 32'(m_rvalid_out), (i == 0) ? 32'h1 : 32'h0);
            check_val("pz_din", 32'(m_din_out), (i == 0) ? 32'h5A : 32'h0);
        end
        cyc;
        pause_in = 1'b0;
        smp;
        check_val("pz_post_gnt", 32'(m_gnt_out), 32'h1);
        cyc;
        m_req_in = 2'b00;
        smp;
        check_val("pz_post_rvalid", 32'(m_rvalid_out), 32'h1);

        // Reset during an outstanding read from master 1 (rr_ptr is 1 here)
        cyc;
        m_req_in = 2'b10;
        smp;
        cyc;
        smp;
        check_val("rr_pre_gnt", 32'(m_gnt_out), 32'h2);
        cyc;
        rst_n_in = 1'b0;
        m_req_in = 2'b11;
        smp;
        check_quiet("mid_rst");
        cyc;
        rst_n_in = 1'b1;
        smp;
        check_val("post_rst_rvalid", 32'(m_rvalid_out), 32'h0);
        check_val("post_rst_gnt", 32'(m_gnt_out), 32'h0);
        cyc;
        smp;
        check_val("post_rst_win_gnt", 32'(m_gnt_out), 32'h1);
        check_val("post_rst_owner", 32'(owner_out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
